// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host-transmit state encoding, default timing constants and parity helper
package ps2_pkg;
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam int PS2_INHIBIT_CYC = 5000;
    localparam int PS2_TIMEOUT_CYC = 1000000;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 2-FF synchronizers for PS2_CLK/PS2_DAT plus falling-edge detect on the clock
//   CLOCK_50    in  system clock
//   Resetn      in  synchronous active-low reset (synchronizers reset to the idle-high level)
//   ps2_clk_in  in  raw PS2_CLK pin
//   ps2_dat_in  in  raw PS2_DAT pin
//   clk_s       out synchronized PS2_CLK
//   dat_s       out synchronized PS2_DAT
//   fe          out one-cycle pulse on a falling edge of clk_s
module ps2_edge_sync (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic fe
);
    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_d;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_ff <= 2'b11;
            dat_ff <= 2'b11;
            clk_d  <= 1'b1;
        end else begin
            clk_ff <= {clk_ff[0], ps2_clk_in};
            dat_ff <= {dat_ff[0], ps2_dat_in};
            clk_d  <= clk_ff[1];
        end
    end

    assign clk_s = clk_ff[1];
    assign dat_s = dat_ff[1];
    assign fe    = clk_d & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, start, 8 data, odd parity, stop, ack)
//   CLOCK_50    in  system clock
//   Resetn      in  synchronous active-low reset
//   tx_data     in  command byte, latched when tx_valid && tx_ready
//   tx_valid    in  send request
//   tx_ready    out high only while idle
//   ps2_clk_in  in  raw PS2_CLK pin level
//   ps2_dat_in  in  raw PS2_DAT pin level
//   ps2_clk_oe  out 1 = pull PS2_CLK low
//   ps2_dat_oe  out 1 = pull PS2_DAT low
//   tx_done     out one-cycle pulse after an acknowledged frame
//   tx_err      out one-cycle pulse on NACK (or watchdog expiry)
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a frame after TIMEOUT_CYC cycles without a clock edge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int IW = $clog2(INHIBIT_CYC + 1);

    ps2_state_t state;
    ps2_state_t state_nxt;
    logic [7:0]    tx_q;
    logic [3:0]    fe_cnt;
    logic [IW-1:0] inh_cnt;
    logic          dat_q;
    logic          dat_nxt;
    logic          clk_s;
    logic          dat_s;
    logic          fe;
    logic          accept;
    logic          inh_done;
    logic          wd_exp;

    ps2_edge_sync u_sync (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .clk_s     (clk_s),
        .dat_s     (dat_s),
        .fe        (fe)
    );

    assign accept   = (state == IDLE) && tx_valid;
    assign inh_done = (state == INHIBIT) && (inh_cnt == IW'(INHIBIT_CYC - 1));

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt;
    logic          timed;
    assign timed  = state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE};
    assign wd_exp = timed && !fe && (wd_cnt == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || !timed || fe)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    // no watchdog in this build; TIMEOUT_CYC stays on the interface so both builds share one instantiation
    assign wd_exp = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            tx_q    <= '0;
            fe_cnt  <= '0;
            inh_cnt <= '0;
            dat_q   <= 1'b0;
        end else begin
            if (accept) begin
                tx_q    <= tx_data;
                fe_cnt  <= '0;
                inh_cnt <= '0;
            end
            if (state == INHIBIT)
                inh_cnt <= inh_cnt + 1'b1;
            if (fe && (state inside {DATA, PARITY, STOP, ACK}))
                fe_cnt <= fe_cnt + 1'b1;
            dat_q <= dat_nxt;
        end
    end

    // fe_cnt holds the number of edges already seen, so it indexes the bit owed on this edge
    always_comb begin
        dat_nxt = inh_done ? 1'b1 :
                  !fe ? dat_q :
                  (state == DATA) ? ~tx_q[fe_cnt[2:0]] :
                  (state == PARITY) ? ~odd_parity(tx_q) :
                  (state == STOP) ? 1'b0 : dat_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tx_valid) state_nxt = INHIBIT;
            INHIBIT:   if (inh_done) state_nxt = DATA;
            DATA:      if (fe && fe_cnt == 4'd7) state_nxt = PARITY;
            PARITY:    if (fe) state_nxt = STOP;
            STOP:      if (fe) state_nxt = ACK;
            ACK:       if (fe) state_nxt = dat_s ? ERR : WAIT_IDLE;
            WAIT_IDLE: if (clk_s && dat_s) state_nxt = IDLE;
            ERR:       state_nxt = IDLE;
        endcase
        if (wd_exp)
            state_nxt = ERR;
    end

    always_comb begin
        tx_ready   = state == IDLE;
        ps2_clk_oe = state == INHIBIT;
        ps2_dat_oe = dat_q && (state inside {DATA, PARITY, STOP});
        tx_done    = Resetn && (state == WAIT_IDLE) && clk_s && dat_s && !wd_exp;
        tx_err     = Resetn && (state == ERR);
    end
endmodule
